adc_spi_sequencer: RTL and testbench

ADC_SPI_SEQUENCER -- requirements
Module: adc_spi_sequencer

---
 rtl/adc_spi_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_adc_spi_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: scans the enabled channels of an 8-input serial ADC over SPI
// and streams conversion results with a valid/ready handshake.
// Optional: define ADC_SEQ_OVERRUN_EN to build the sticky overrun flag.
`timescale 1ns/1ps
module adc_spi_sequencer #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned DW      = 12,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [NCH-1:0] ch_mask,
  input  logic          sdat,
  output logic          saddr,
  output logic          sclk,
  output logic          cs_n,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_ch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          end_of_scan,
  output logic          busy,
  output logic          overrun
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, FRAME, HOLD} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_edge;
  logic             r_sclk;
  logic             r_cs_n;
  logic             r_saddr;
  logic             r_dummy;
  logic [2:0]       r_ptr;
  logic [2:0]       r_addr;
  logic [2:0]       r_data_ch;
  logic [DW-1:0]    r_shift;
  logic [DW-1:0]    r_data;
  logic [2:0]       r_ch;
  logic             r_valid;
  logic             r_eos;
  logic             r_busy;

  logic             w_div_end;
  logic             w_mask_any;
  logic             w_new_result;
  logic [DW-1:0]    w_shift_next;
  logic [2:0]       w_sel;
  logic [2:0]       w_ptr_next;
  logic [2:0]       w_high;
  logic [2:0]       w_low;
  logic [2:0]       w_first;
  logic             w_low_found;
  logic             w_first_found;

  assign w_div_end    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_mask_any   = |ch_mask;
  assign w_shift_next = (r_shift << 1) | DW'(sdat);
  assign w_new_result = (r_state == FRAME) && w_div_end && !r_sclk &&
                        (r_edge == 5'd31) && !r_dummy;

  // Channel selection: next set bit at or above the pointer, else wrap to lowest set bit
  always_comb begin
    w_low         = 3'd0;
    w_first       = 3'd0;
    w_high        = 3'd0;
    w_low_found   = 1'b0;
    w_first_found = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_mask[i]) begin
        if (!w_low_found) begin
          w_low       = 3'(i);
          w_low_found = 1'b1;
        end
        if (!w_first_found && (3'(i) >= r_ptr)) begin
          w_first       = 3'(i);
          w_first_found = 1'b1;
        end
        w_high = 3'(i);
      end
    end
    w_sel      = w_first_found ? w_first : w_low;
    w_ptr_next = (w_sel == 3'(NCH - 1)) ? 3'd0 : w_sel + 3'd1;
  end

  // Sequencer FSM: SPI framing, address pipeline, result capture and handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_edge    <= '0;
      r_sclk    <= 1'b1;
      r_cs_n    <= 1'b1;
      r_saddr   <= 1'b0;
      r_dummy   <= 1'b1;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_data_ch <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_ch      <= '0;
      r_valid   <= 1'b0;
      r_eos     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_eos <= 1'b0;
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b1;
          r_saddr <= 1'b0;
          r_div   <= '0;
          if (enable && w_mask_any) begin
            r_state <= SETUP;
            r_cs_n  <= 1'b0;
            r_dummy <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (w_div_end) begin
            r_state <= FRAME;
            r_div   <= '0;
            r_edge  <= '0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        FRAME: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 5'd1;
            if (r_sclk) begin
              // falling edge: drive the address for the frame after this one
              case (r_edge)
                5'd4: begin
                  r_addr  <= w_sel;
                  r_saddr <= w_sel[2];
                  r_ptr   <= w_ptr_next;
                end
                5'd6:    r_saddr <= r_addr[1];
                5'd8:    r_saddr <= r_addr[0];
                default: r_saddr <= 1'b0;
              endcase
            end else begin
              r_shift <= w_shift_next;
              if (r_edge == 5'd31) begin
                if (w_new_result) begin
                  r_valid <= 1'b1;
                  r_data  <= w_shift_next;
                  r_ch    <= r_data_ch;
                  r_eos   <= (r_data_ch == w_high);
                end
                if (enable && w_mask_any) begin
                  r_dummy   <= 1'b0;
                  r_data_ch <= r_addr;
                end else begin
                  r_state <= HOLD;
                end
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        HOLD: begin
          if (w_div_end) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_div   <= '0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SEQ_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: a pending result was overwritten before being accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if ((r_state == IDLE) && !enable) begin
      r_overrun <= 1'b0;
    end else if (w_new_result && r_valid && !out_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign sclk        = r_sclk;
  assign cs_n        = r_cs_n;
  assign saddr       = r_saddr;
  assign out_data    = r_data;
  assign out_ch      = r_ch;
  assign out_valid   = r_valid;
  assign end_of_scan = r_eos;
  assign busy        = r_busy;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Testbench for adc_spi_sequencer with a behavioural serial ADC model and a result scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_sequencer;

  localparam int unsigned NCH     = 8;
  localparam int unsigned DW      = 12;
  localparam int unsigned CLK_DIV = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    ch_mask = 8'h00;
  logic          sdat = 1'b0;
  logic          out_ready = 1'b0;
  logic          saddr, sclk, cs_n;
  logic [11:0]   out_data;
  logic [2:0]    out_ch;
  logic          out_valid, end_of_scan, busy, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  ch;
    logic        eos;
  } exp_t;

  exp_t sb[$];

`ifdef ADC_SEQ_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  adc_spi_sequencer #(.NCH(NCH), .DW(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .sdat(sdat),
    .saddr(saddr), .sclk(sclk), .cs_n(cs_n), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .end_of_scan(end_of_scan),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ADC model: address in frame N selects the conversion shifted out in frame N+1
  int          adc_p = 0;
  logic [2:0]  adc_cur = 3'd0;
  logic [2:0]  adc_next = 3'd0;
  logic [2:0]  adc_rx = 3'd0;
  logic [11:0] adc_word = 12'd0;

  always @(posedge cs_n) adc_p = 0;

  always @(negedge sclk) begin
    if (cs_n === 1'b0) begin
      adc_p = (adc_p >= 16) ? 1 : adc_p + 1;
      if (adc_p == 1) adc_cur = adc_next;
      adc_word = 12'hA50 | {9'd0, adc_cur};
      sdat = (adc_p > 16 - int'(DW)) ? adc_word[16 - adc_p] : 1'b0;
    end
  end

  always @(posedge sclk) begin
    if (cs_n === 1'b0 && adc_p >= 3 && adc_p <= 5) begin
      adc_rx[5 - adc_p] = saddr;
      if (adc_p == 5) adc_next = adc_rx;
    end
  end

  function automatic exp_t mk(input logic [2:0] ch, input logic eos);
    exp_t e;
    e.data = 12'hA50 | {9'd0, ch};
    e.ch   = ch;
    e.eos  = eos;
    return e;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    ch_mask   = 8'h00;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (sampling on falling clk) until out_valid is seen or the budget runs out
  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_adc_period(input int p, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (adc_p == p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs_n, sclk, saddr, out_valid, end_of_scan, busy, overrun} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_ctrl: cs_n,sclk,saddr,valid,eos,busy,ovr=%b required 1100000",
               {cs_n, sclk, saddr, out_valid, end_of_scan, busy, overrun});
    end
    checks++;
    if (out_data !== 12'h000 || out_ch !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h ch=%0d required 000/0", out_data, out_ch);
    end
  endtask

  task automatic test_scan();
    int n;
    bit ok;
    exp_t e;
    int idx;
    do_reset();
    ch_mask   = 8'h24;
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back((k % 2 == 0) ? mk(3'd2, 1'b0) : mk(3'd5, 1'b1));
    idx = 0;
    while (sb.size() > 0) begin
      wait_valid(300, n, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL scan_timeout: no result %0d within 300 cycles", idx);
        return;
      end
      e = sb.pop_front();
      if (sb.size() == 1) enable = 1'b0;
      checks++;
      if (out_data !== e.data || out_ch !== e.ch) begin
        errors++;
        $display("FAIL scan_data[%0d]: ch=%0d data=%h required ch=%0d data=%h",
                 idx, out_ch, out_data, e.ch, e.data);
      end
      checks++;
      if (end_of_scan !== e.eos) begin
        errors++;
        $display("FAIL scan_eos[%0d]: got %b required %b", idx, end_of_scan, e.eos);
      end
      checks++;
      if (n !== ((idx == 0) ? 131 : 64)) begin
        errors++;
        $display("FAIL scan_period[%0d]: %0d cycles required %0d", idx, n, (idx == 0) ? 131 : 64);
      end
      idx++;
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0 || sclk !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_hold: cs_n=%b sclk=%b busy=%b required 0 1 1", cs_n, sclk, busy);
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_idle: cs_n=%b busy=%b required 1 0", cs_n, busy);
    end
  endtask

  task automatic test_empty_mask();
    do_reset();
    ch_mask = 8'h00;
    enable  = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      checks++;
      if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_mask@%0d: cs_n=%b sclk=%b busy=%b required 1 1 0", k, cs_n, sclk, busy);
        break;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit got;
    bit first;
    logic [2:0] last_ch;
    int waited;
    do_reset();
    ch_mask   = 8'h24;
    out_ready = 1'b0;
    enable    = 1'b1;
    sb.push_back(mk(3'd2, 1'b0));
    sb.push_back(mk(3'd5, 1'b1));
    sb.push_back(mk(3'd2, 1'b0));
    first   = 1'b1;
    last_ch = 3'd0;
    for (int r = 0; r < 3; r++) begin
      got = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1 && (first || out_ch !== last_ch)) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL bp_timeout: result %0d not seen", r);
        return;
      end
      first   = 1'b0;
      last_ch = out_ch;
      e = sb.pop_front();
      if (r == 1) enable = 1'b0;
      checks++;
      if (out_data !== e.data || out_ch !== e.ch) begin
        errors++;
        $display("FAIL bp_data[%0d]: ch=%0d data=%h required ch=%0d data=%h",
                 r, out_ch, out_data, e.ch, e.data);
      end
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: busy=%b required 0", busy);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'hA52 || out_ch !== 3'd2) begin
      errors++;
      $display("FAIL bp_hold: valid=%b ch=%0d data=%h required 1 2 a52", out_valid, out_ch, out_data);
    end
    checks++;
    if (overrun !== EXP_OVR) begin
      errors++;
      $display("FAIL bp_overrun: got %b required %b", overrun, EXP_OVR);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b overrun=%b required 0 0", out_valid, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    bit ok;
    exp_t e;
    do_reset();
    ch_mask   = 8'h24;
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_valid(300, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_first: no first result");
      return;
    end
    wait_adc_period(9, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_period: period 9 not reached");
      return;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sclk !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_abort: cs_n=%b valid=%b busy=%b sclk=%b required 1 0 0 1",
               cs_n, out_valid, busy, sclk);
    end
    rst_n = 1'b1;
    sb.push_back(mk(3'd2, 1'b0));
    wait_valid(300, n, ok);
    checks++;
    if (!ok || n !== 131) begin
      errors++;
      $display("FAIL rst_mid_dummy: first result after %0d cycles (seen=%b) required 131", n, ok);
    end
    e = sb.pop_front();
    checks++;
    if (out_data !== e.data || out_ch !== e.ch) begin
      errors++;
      $display("FAIL rst_mid_data: ch=%0d data=%h required ch=%0d data=%h", out_ch, out_data, e.ch, e.data);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n;
    bit ok;
    bit stray;
    exp_t e;
    do_reset();
    ch_mask   = 8'h0A;
    out_ready = 1'b1;
    enable    = 1'b1;
    sb.push_back(mk(3'd1, 1'b0));
    sb.push_back(mk(3'd3, 1'b1));
    for (int r = 0; r < 2; r++) begin
      wait_valid(300, n, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL drop_timeout: result %0d not seen", r);
        return;
      end
      e = sb.pop_front();
      checks++;
      if (out_data !== e.data || out_ch !== e.ch || end_of_scan !== e.eos) begin
        errors++;
        $display("FAIL drop_data[%0d]: ch=%0d data=%h eos=%b required ch=%0d data=%h eos=%b",
                 r, out_ch, out_data, end_of_scan, e.ch, e.data, e.eos);
      end
      if (r == 0) begin
        wait_adc_period(4, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL drop_period: period 4 not reached");
          return;
        end
        enable = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0 || sclk !== 1'b1) begin
      errors++;
      $display("FAIL drop_hold: cs_n=%b sclk=%b required 0 1", cs_n, sclk);
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_csn_rise: cs_n=%b busy=%b required 1 0", cs_n, busy);
    end
    stray = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || cs_n !== 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL drop_quiet: activity after scan stopped, required none");
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_empty_mask();
    test_backpressure();
    test_reset_midframe();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
